// File: rtl/fifo_drain_framer.sv
// fifo_drain_framer: drains a fall-through FIFO read port into a valid/ready
// stream framed into packets of BURST words; an idle FIFO closes a partial
// packet after TOUT cycles.
//   rclk, rrst            read clock, async active-high reset
//   rdata, rempty, rinc   FIFO head word, empty flag, pop strobe
//   m_data, m_valid,
//   m_last, m_ready       output stream
//   pkt_cnt               completed packets, wraps at 2^16
module fifo_drain_framer #(
    parameter int DSIZE = 8,
    parameter int BURST = 4,
    parameter int TOUT  = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [15:0]      pkt_cnt
);
    localparam int BW = BURST > 1 ? $clog2(BURST) : 1;
    localparam int IW = TOUT > 1 ? $clog2(TOUT) : 1;
    typedef enum logic [1:0] {EMPTY, HOLD, CLOSE} state_t;
    state_t           state_q, state_d;
    logic [DSIZE-1:0] h_data_q, h_data_d, o_data_q, o_data_d;
    logic [BW-1:0]    h_beat_q, h_beat_d, beat_q, beat_d;
    logic [IW-1:0]    idle_q, idle_d;
    logic             o_valid_q, o_valid_d, o_last_q, o_last_d;
    logic [15:0]      pkt_q, pkt_d;
    logic             h_valid, o_free, h_final, tout, close, h_move, pop;
    // H is occupied in both HOLD and CLOSE; CLOSE marks a timed-out word
    // waiting for the output register to drain.
    assign h_valid = state_q != EMPTY;
    assign o_free  = !o_valid_q || m_ready;
    assign h_final = h_valid && h_beat_q == BW'(BURST - 1);
    assign tout    = h_valid && !h_final && idle_q == IW'(TOUT - 1);
    // A timeout only ends the packet if no new word is there to continue it.
    assign close   = tout && rempty;
    assign h_move  = h_valid && o_free && (h_final || !rempty || tout);
    assign pop     = !rrst && !rempty && (!h_valid || h_move);
    assign rinc    = pop;
    assign m_data  = o_data_q;
    assign m_valid = o_valid_q;
    assign m_last  = o_last_q;
    assign pkt_cnt = pkt_q;
    always_comb begin
        state_d   = pop ? HOLD : h_move ? EMPTY : (tout && !o_free) ? CLOSE : state_q;
        h_data_d  = pop ? rdata : h_data_q;
        h_beat_d  = pop ? beat_q : h_beat_q;
        beat_d    = pop ? (beat_q == BW'(BURST - 1) ? '0 : beat_q + BW'(1))
                  : (h_move && close) ? '0 : beat_q;
        // Saturating at TOUT-1 keeps the timeout pending while O is blocked.
        idle_d    = (pop || !h_valid) ? '0
                  : (!h_final && rempty && idle_q != IW'(TOUT - 1)) ? idle_q + IW'(1) : idle_q;
        o_data_d  = h_move ? h_data_q : o_data_q;
        o_last_d  = h_move ? (h_final || close) : o_last_q;
        o_valid_d = h_move || (o_valid_q && !m_ready);
        pkt_d     = pkt_q + 16'(o_valid_q && m_ready && o_last_q);
    end
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state_q   <= EMPTY;
            h_data_q  <= '0;
            h_beat_q  <= '0;
            beat_q    <= '0;
            idle_q    <= '0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            pkt_q     <= '0;
        end else begin
            state_q   <= state_d;
            h_data_q  <= h_data_d;
            h_beat_q  <= h_beat_d;
            beat_q    <= beat_d;
            idle_q    <= idle_d;
            o_data_q  <= o_data_d;
            o_valid_q <= o_valid_d;
            o_last_q  <= o_last_d;
            pkt_q     <= pkt_d;
        end
    end
endmodule

// File: tb/tb_fifo_drain_framer.sv
// tb_fifo_drain_framer: directed bench for fifo_drain_framer (BURST=4, TOUT=16)
// driving a behavioural fall-through FIFO and logging accepted stream beats.
module tb_fifo_drain_framer;
    logic        rclk = 1'b0, rrst = 1'b1, m_ready = 1'b1;
    logic        rempty, rinc, m_valid, m_last;
    logic [7:0]  rdata, m_data;
    logic [15:0] pkt_cnt;
    logic [7:0]  mem [0:63];
    int          head = 0, tail = 0, cyc = 0, nlog = 0;
    logic [8:0]  log_q [0:63];
    int          cyc_q [0:63];
    int          n_assert = 0, n_fail = 0, base = 0, k = 0, h0 = 0;

    fifo_drain_framer #(.DSIZE(8), .BURST(4), .TOUT(16)) dut (
        .rclk(rclk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rinc(rinc),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .pkt_cnt(pkt_cnt)
    );

    always #5 rclk = ~rclk;

    assign rempty = head == tail;
    assign rdata  = mem[head[5:0]];

    always @(posedge rclk) begin
        cyc <= cyc + 1;
        if (rinc) head <= head + 1;
        if (m_valid && m_ready) begin
            log_q[nlog] <= {m_last, m_data};
            cyc_q[nlog] <= cyc;
            nlog <= nlog + 1;
        end
    end

    task automatic push(input logic [7:0] d);
        mem[tail[5:0]] = d;
        tail++;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset with data waiting
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        repeat (3) @(posedge rclk);
        @(negedge rclk);
        chk("rst_rinc", 16'(rinc), 16'd0);
        chk("rst_valid", 16'(m_valid), 16'd0);
        chk("rst_last", 16'(m_last), 16'd0);
        chk("rst_data", 16'(m_data), 16'd0);
        chk("rst_pkt", pkt_cnt, 16'd0);
        rrst = 1'b0;
        #1 chk("first_rinc", 16'(rinc), 16'd1);
        // two full packets back to back
        repeat (14) @(negedge rclk);
        chk("b2_count", 16'(nlog), 16'd8);
        for (int i = 0; i < 8; i++)
            chk("b2_beat", 16'(log_q[i]), 16'({(i == 3 || i == 7), 8'(8'h10 + i)}));
        chk("b2_rate", 16'(cyc_q[7] - cyc_q[0]), 16'd7);
        chk("b2_pkt", pkt_cnt, 16'd2);
        // timeout closes a two-word packet
        base = nlog;
        push(8'h20);
        push(8'h21);
        @(negedge rclk);
        k = 0;
        while (!(m_valid && m_last) && k < 40) begin
            @(negedge rclk);
            k++;
        end
        chk("tout_lat", 16'(k), 16'd17);
        chk("tout_data", 16'(m_data), 16'h21);
        @(negedge rclk);
        chk("tout_w0", 16'(log_q[base]), 16'h020);
        chk("tout_w1", 16'(log_q[base + 1]), 16'h121);
        chk("tout_pkt", pkt_cnt, 16'd3);
        push(8'h30); push(8'h31); push(8'h32); push(8'h33);
        repeat (8) @(negedge rclk);
        for (int i = 0; i < 4; i++)
            chk("tout_next", 16'(log_q[base + 2 + i]), 16'({(i == 3), 8'(8'h30 + i)}));
        chk("tout_next_pkt", pkt_cnt, 16'd4);
        // backpressure with a full FIFO
        base = nlog;
        h0 = head;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(8'h40 + i));
        repeat (10) @(negedge rclk);
        chk("bp_pops", 16'(head - h0), 16'd2);
        chk("bp_valid", 16'(m_valid), 16'd1);
        chk("bp_data", 16'(m_data), 16'h40);
        chk("bp_none", 16'(nlog - base), 16'd0);
        m_ready = 1'b1;
        repeat (12) @(negedge rclk);
        chk("bp_count", 16'(nlog - base), 16'd8);
        for (int i = 0; i < 8; i++)
            chk("bp_beat", 16'(log_q[base + i]), 16'({(i == 3 || i == 7), 8'(8'h40 + i)}));
        chk("bp_pkt", pkt_cnt, 16'd6);
        // data arrives on the exact timeout cycle
        base = nlog;
        push(8'h50);
        repeat (16) @(negedge rclk);
        chk("race_pre", 16'(m_valid), 16'd0);
        push(8'h51); push(8'h52); push(8'h53);
        @(negedge rclk);
        chk("race_valid", 16'(m_valid), 16'd1);
        chk("race_data", 16'(m_data), 16'h50);
        chk("race_last", 16'(m_last), 16'd0);
        repeat (6) @(negedge rclk);
        for (int i = 0; i < 4; i++)
            chk("race_beat", 16'(log_q[base + i]), 16'({(i == 3), 8'(8'h50 + i)}));
        chk("race_pkt", pkt_cnt, 16'd7);
        // reset with H and O occupied mid-packet
        m_ready = 1'b0;
        push(8'h60); push(8'h61); push(8'h62); push(8'h63);
        repeat (3) @(negedge rclk);
        chk("mid_held", 16'(m_data), 16'h60);
        rrst = 1'b1;
        tail = head;
        #1;
        chk("mid_rst_valid", 16'(m_valid), 16'd0);
        chk("mid_rst_data", 16'(m_data), 16'd0);
        chk("mid_rst_last", 16'(m_last), 16'd0);
        chk("mid_rst_pkt", pkt_cnt, 16'd0);
        chk("mid_rst_rinc", 16'(rinc), 16'd0);
        @(negedge rclk);
        rrst = 1'b0;
        m_ready = 1'b1;
        base = nlog;
        push(8'h70); push(8'h71); push(8'h72); push(8'h73);
        repeat (8) @(negedge rclk);
        chk("post_count", 16'(nlog - base), 16'd4);
        for (int i = 0; i < 4; i++)
            chk("post_beat", 16'(log_q[base + i]), 16'({(i == 3), 8'(8'h70 + i)}));
        chk("post_pkt", pkt_cnt, 16'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
